citadel_resp_buf: RTL and testbench
===================================

// Module: citadel_resp_buf
// PURPOSE
//  Response buffer directly downstream of citadel_fpu on the Nexys4-DDR test top.
//  Accepts words from citadel's cmd_resp genfifo into a FIFO and exposes them to the
//  UDM debug bus as memory-mapped registers (pop-on-read data, status, control), so
//  back-to-back FPU results are never lost or overwritten.
// PARAMETERS
//  DEPTH_POW   4               FIFO depth = 2**DEPTH_POW words (32-bit)
//  BASE_ADDR   32'h10000040    byte base of 16-byte register window (4-byte aligned)
// PORTS
//  clk_i                 in   1   system clock
//  rst_ni                in   1   reset, asynchronous, active-low
//  resp_genfifo_req_i    in   1   citadel result valid
//  resp_genfifo_wdata_bi in   32  citadel result word
//  resp_genfifo_ack_o    out  1   result accepted (= !full)
//  bus_req_i             in   1   UDM bus request
//  bus_we_i              in   1   1 = write, 0 = read
//  bus_addr_bi           in   32  byte address
//  bus_be_bi             in   4   byte enables (ignored; full-word access only)
//  bus_wdata_bi          in   32  write data
//  bus_ack_o             out  1   request accepted
//  bus_resp_o            out  1   read response valid
//  bus_rdata_bo          out  32  read data
// BEHAVIOUR
//  Reset: FIFO empty, count 0, underflow 0, bus_resp_o 0, bus_rdata_bo 0;
//   resp_genfifo_ack_o 0 while rst_ni low, 1 from first edge after release.
//  Window hit: bus_addr_bi in [BASE_ADDR, BASE_ADDR+16); misses get ack only, no resp.
//  bus_ack_o = bus_req_i (combinational, never stalls).
//  Push: req_i && ack_o at posedge -> write wdata at wr_ptr, wr_ptr++, count++.
//  Registers (offset):
//   0x0 RDATA  R: returns head word, pops. If empty: returns 0, sets underflow, no pop.
//   0x4 STATUS R: [0]=empty [1]=full [2]=underflow [DEPTH_POW+8:8]=count; rest 0.
//   0x8 CTRL   W: [0]=flush (ptrs/count to 0), [1]=clear underflow. R returns 0.
//   0xC TSTAMP R: see CONFIGURATION; returns 0 when feature absent.
//  Writes to 0x0/0x4/0xC ignored. Reads never alter state except the 0x0 pop.
//  Read latency: bus_resp_o pulses exactly 1 cycle after accept, with bus_rdata_bo
//   registered in same cycle; bus_rdata_bo holds 0 when bus_resp_o is 0.
//  STATUS/head sampled from registered state at accept edge (pre-push/pre-pop).
//  Simultaneous push + pop: both occur, count unchanged; FIFO order preserved.
//  Full: ack_o = 0 (citadel stalls); a pop in same cycle does NOT admit the push
//   (ack_o is from registered full only); push lands next cycle.
//  Flush + push same cycle: flush wins, pushed word discarded, result empty.
//  Pointers DEPTH_POW bits, wrap modulo depth; count DEPTH_POW+1 bits, 0..2**DEPTH_POW.
//  Reset mid-operation: all contents discarded, pending read response dropped.
// CONFIGURATION
//  CITADEL_RESP_TIMESTAMP_EN defined: free-running 32-bit cycle counter (reset 0,
//   wraps); each pushed word stores counter value at push edge in parallel array;
//   TSTAMP (0xC) returns head entry's stamp without popping (0 if empty).
//  Undefined: no counter/array; TSTAMP reads 0; all else identical.
// STRUCTURE
//  Shared package citadel_resp_pkg: offset localparams (RDATA/STATUS/CTRL/TSTAMP),
//   STATUS bit positions, CTRL bit positions.
//  Sub-module citadel_resp_fifo: storage + pointers + count + full/empty
//   (push/pop/flush inputs); top handles bus decode and response register.
// TESTING
//  1 Reset, read 0x4 -> resp 1 cycle later, rdata 32'h0000_0001 (empty).
//  2 Push 3 words A,B,C; read 0x4 -> count 3; three 0x0 reads -> A,B,C; then empty.
//  3 Push 17 words with DEPTH_POW=4 -> ack_o low after 16th; pop 1 -> 17th lands next
//   cycle; count 16; read-out order intact across pointer wrap.
//  4 Read 0x0 when empty -> rdata 0, STATUS[2]=1; write 0x8=2 -> STATUS[2]=0.
//  5 Hold push each cycle while popping each cycle -> count constant, no loss;
//   write 0x8=1 concurrent with push -> count 0, empty.
//  6 With macro: push at counter T0,T1; read 0xC -> T0; pop; read 0xC -> T1.

Source files
------------

// File: rtl/citadel_resp_pkg.sv
// Register map shared by the citadel response buffer and its FIFO.
// Offsets are byte offsets inside the 16-byte bus window.
package citadel_resp_pkg;

    localparam logic [3:0] OFF_RDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_TSTAMP = 4'hC;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_UNDERFLOW = 2;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CTRL_FLUSH         = 0;
    localparam int CTRL_CLR_UNDERFLOW = 1;

endpackage

// File: rtl/citadel_resp_fifo.sv
// Purpose: circular word store with pointers, occupancy count and full/empty flags.
// Latency: push visible at head the cycle after the push edge; head is a combinational read.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module citadel_resp_fifo #(
    parameter int DEPTH_POW = 4,
    parameter int W         = 32
) (
    input  logic                 clk_gen,
    input  logic                 arst_n,
    input  logic                 push,
    input  logic [W-1:0]         push_dat,
    input  logic                 pop,
    input  logic                 flush,
    output logic [W-1:0]         head_dat,
    output logic [DEPTH_POW:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << DEPTH_POW;

    logic [W-1:0]           mem [DEPTH];
    logic [DEPTH_POW-1:0]   wr_ptr;
    logic [DEPTH_POW-1:0]   rd_ptr;

    always_ff @(posedge clk_gen) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Flush dominates any push or pop presented in the same cycle.
    always_ff @(posedge clk_gen or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (DEPTH_POW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/citadel_resp_buf.sv
// Purpose: buffers citadel FPU results and serves them as UDM bus registers (optional CITADEL_RESP_TIMESTAMP_EN).
// Latency: read response one cycle after accept; bus_ack_o is combinational and never stalls.
// Backpressure: resp_genfifo_ack_o drops while the FIFO is full (registered flag, a same-cycle pop does not admit).
module citadel_resp_buf
    import citadel_resp_pkg::*;
#(
    parameter int          DEPTH_POW = 4,
    parameter logic [31:0] BASE_ADDR = 32'h10000040
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        resp_genfifo_req_i,
    input  logic [31:0] resp_genfifo_wdata_bi,
    output logic        resp_genfifo_ack_o,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo
);

`ifdef CITADEL_RESP_TIMESTAMP_EN
    localparam int FIFO_W = 64;
`else
    localparam int FIFO_W = 32;
`endif

    logic [FIFO_W-1:0]    push_dat;
    logic [FIFO_W-1:0]    head_dat;
    logic [DEPTH_POW:0]   count;
    logic                 full;
    logic                 empty;
    logic [31:0]          head_stamp;
    logic                 in_rdy;
    logic                 underflow;
    logic [31:0]          off;
    logic [3:0]           sel;
    logic                 hit;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic [31:0]          rd_val;
    logic                 unused_bits;

`ifdef CITADEL_RESP_TIMESTAMP_EN
    logic [31:0] tstamp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tstamp <= '0;
        else         tstamp <= tstamp + 32'd1;
    end

    assign push_dat   = {tstamp, resp_genfifo_wdata_bi};
    assign head_stamp = head_dat[63:32];
`else
    assign push_dat   = resp_genfifo_wdata_bi;
    assign head_stamp = '0;
`endif

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign off    = bus_addr_bi - BASE_ADDR;
    assign hit    = (off < 32'd16);
    assign sel    = {off[3:2], 2'b00};
    assign rd_acc = bus_req_i && !bus_we_i && hit;
    assign wr_acc = bus_req_i &&  bus_we_i && hit;

    assign bus_ack_o          = bus_req_i;
    assign resp_genfifo_ack_o = in_rdy && !full;
    assign push  = resp_genfifo_req_i && resp_genfifo_ack_o;
    assign pop   = rd_acc && (sel == OFF_RDATA) && !empty;
    assign flush = wr_acc && (sel == OFF_CTRL) && bus_wdata_bi[CTRL_FLUSH];

    citadel_resp_fifo #(
        .DEPTH_POW (DEPTH_POW),
        .W         (FIFO_W)
    ) u_fifo (
        .clk_gen   (clk_i),
        .arst_n    (rst_ni),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .flush     (flush),
        .head_dat  (head_dat),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        rd_val = '0;
        case (sel)
            OFF_RDATA:  if (!empty) rd_val = head_dat[31:0];
            OFF_STATUS: begin
                rd_val[STATUS_EMPTY]                        = empty;
                rd_val[STATUS_FULL]                         = full;
                rd_val[STATUS_UNDERFLOW]                    = underflow;
                rd_val[STATUS_COUNT_LSB +: DEPTH_POW+1]     = count;
            end
            OFF_TSTAMP: if (!empty) rd_val = head_stamp;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_rdy       <= 1'b0;
            underflow    <= 1'b0;
            bus_resp_o   <= 1'b0;
            bus_rdata_bo <= '0;
        end else begin
            in_rdy       <= 1'b1;
            bus_resp_o   <= rd_acc;
            bus_rdata_bo <= rd_acc ? rd_val : '0;
            if (rd_acc && (sel == OFF_RDATA) && empty) begin
                underflow <= 1'b1;
            end else if (wr_acc && (sel == OFF_CTRL) && bus_wdata_bi[CTRL_CLR_UNDERFLOW]) begin
                underflow <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{bus_be_bi, off[1:0], bus_wdata_bi[31:2]};

endmodule

// File: tb/tb_citadel_resp_buf.sv
// Randomised bench for citadel_resp_buf against a queue-based model of the register map.
module tb_citadel_resp_buf;

    localparam int          DP    = 4;
    localparam int          DEPTH = 1 << DP;
    localparam logic [31:0] BASE  = 32'h10000040;

    logic        clk_gen = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] wdata;
    logic        ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_resp;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_dat[$];
    logic [31:0] q_ts[$];
    logic        uf_m;
    logic        rdy_m;
    logic [31:0] tcnt;

    always #5 clk_gen = ~clk_gen;

    citadel_resp_buf #(.DEPTH_POW(DP), .BASE_ADDR(BASE)) dut (
        .clk_i                 (clk_gen),
        .rst_ni                (rst_n),
        .resp_genfifo_req_i    (req),
        .resp_genfifo_wdata_bi (wdata),
        .resp_genfifo_ack_o    (ack),
        .bus_req_i             (bus_req),
        .bus_we_i              (bus_we),
        .bus_addr_bi           (bus_addr),
        .bus_be_bi             (bus_be),
        .bus_wdata_bi          (bus_wdata),
        .bus_ack_o             (bus_ack),
        .bus_resp_o            (bus_resp),
        .bus_rdata_bo          (bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_dat.delete();
        q_ts.delete();
        uf_m  = 1'b0;
        rdy_m = 1'b0;
        tcnt  = '0;
    endtask

    // One clock: drive, check combinational acks, clock, check the read response, advance model.
    task automatic step(input logic r, input logic [31:0] wd, input logic breq, input logic we,
                        input logic [31:0] addr, input logic [31:0] bwd, output logic accepted);
        logic        ack_e, hit, rd, wr, resp_e, do_pop, do_push, do_flush;
        logic [31:0] off, rdata_e;
        int          n;
        req = r; wdata = wd; bus_req = breq; bus_we = we; bus_addr = addr;
        bus_wdata = bwd; bus_be = 4'($urandom);
        n      = q_dat.size();
        ack_e  = rdy_m && (n < DEPTH);
        off    = addr - BASE;
        hit    = breq && (addr >= BASE) && (addr < BASE + 32'd16);
        rd     = hit && !we;
        wr     = hit && we;
        resp_e = rd;
        rdata_e = '0;
        if (rd) begin
            case (off[3:2])
                2'd0: rdata_e = (n > 0) ? q_dat[0] : 32'd0;
                2'd1: rdata_e = (32'(n) << 8) | (32'(uf_m) << 2) |
                                (32'(n == DEPTH) << 1) | 32'(n == 0);
                2'd2: rdata_e = 32'd0;
`ifdef CITADEL_RESP_TIMESTAMP_EN
                2'd3: rdata_e = (n > 0) ? q_ts[0] : 32'd0;
`else
                2'd3: rdata_e = 32'd0;
`endif
                default: rdata_e = 32'd0;
            endcase
        end
        #1;
        check_eq("genfifo_ack", 32'(ack), 32'(ack_e));
        check_eq("bus_ack", 32'(bus_ack), 32'(breq));
        @(posedge clk_gen);
        #1;
        check_eq("bus_resp", 32'(bus_resp), 32'(resp_e));
        check_eq("bus_rdata", bus_rdata, rdata_e);
        do_pop   = rd && (off[3:2] == 2'd0) && (n > 0);
        do_push  = r && ack_e;
        do_flush = wr && (off[3:2] == 2'd2) && bwd[0];
        if (rd && (off[3:2] == 2'd0) && (n == 0)) uf_m = 1'b1;
        else if (wr && (off[3:2] == 2'd2) && bwd[1]) uf_m = 1'b0;
        if (do_flush) begin
            q_dat.delete();
            q_ts.delete();
        end else begin
            if (do_pop) begin
                void'(q_dat.pop_front());
                void'(q_ts.pop_front());
            end
            if (do_push) begin
                q_dat.push_back(wd);
                q_ts.push_back(tcnt);
            end
        end
        accepted = do_push && !do_flush;
        tcnt  = tcnt + 32'd1;
        rdy_m = 1'b1;
    endtask

    task automatic push_w(input logic [31:0] w, output logic accepted);
        step(1'b1, w, 1'b0, 1'b0, 32'd0, 32'd0, accepted);
    endtask

    task automatic rd_reg(input logic [3:0] o);
        logic a;
        step(1'b0, 32'd0, 1'b1, 1'b0, BASE + 32'(o), 32'd0, a);
    endtask

    task automatic wr_reg(input logic [3:0] o, input logic [31:0] v);
        logic a;
        step(1'b0, 32'd0, 1'b1, 1'b1, BASE + 32'(o), v, a);
    endtask

    initial begin
        logic        a;
        logic [31:0] words [17];
        logic [31:0] addr;
        int          idx, op;
        rst_n = 1'b0; req = 1'b0; wdata = '0; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_be = '0; bus_wdata = '0;
        model_reset();
        #2;
        check_eq("rst_genfifo_ack", 32'(ack), 32'd0);
        check_eq("rst_resp", 32'(bus_resp), 32'd0);
        check_eq("rst_rdata", bus_rdata, 32'd0);
        repeat (3) @(posedge clk_gen);
        @(negedge clk_gen);
        rst_n = 1'b1;

        // Reset state and a simple three-word round trip.
        rd_reg(4'h4);
        push_w(32'hAAAA_0001, a);
        push_w(32'hBBBB_0002, a);
        push_w(32'hCCCC_0003, a);
        rd_reg(4'h4);
        rd_reg(4'hC);
        repeat (4) rd_reg(4'h0);
        rd_reg(4'h4);

        // Fill past full with a held request; pointers wrap from offset 3.
        for (int i = 0; i < 17; i++) words[i] = $urandom;
        idx = 0;
        for (int k = 0; k < 40 && idx < 16; k++) begin
            push_w(words[idx], a);
            if (a) idx++;
        end
        push_w(words[16], a);
        push_w(words[16], a);
        step(1'b1, words[16], 1'b1, 1'b0, BASE, 32'd0, a);
        push_w(words[16], a);
        rd_reg(4'h4);
        repeat (17) rd_reg(4'h0);

        // Underflow set and cleared.
        rd_reg(4'h4);
        wr_reg(4'h8, 32'd2);
        rd_reg(4'h4);

        // Steady push+pop, then flush racing a push.
        push_w(32'h1234_5678, a);
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1, 1'b0, BASE, 32'd0, a);
        rd_reg(4'h4);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, BASE + 32'h8, 32'd1, a);
        rd_reg(4'h4);

        // Random traffic over every register, ignored writes and window misses.
        for (int c = 0; c < 1500; c++) begin
            op = $urandom_range(0, 9);
            case (op)
                3: addr = BASE;
                4: addr = BASE + 32'h4;
                5: addr = BASE + 32'hC;
                6, 7: addr = BASE + 32'h8;
                8: addr = BASE + 32'(4 * ($urandom_range(0, 2) == 2 ? 3 : $urandom_range(0, 1)));
                9: addr = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'd16 + 32'($urandom_range(0, 64));
                default: addr = BASE;
            endcase
            step((c < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom,
                 op >= 3,
                 (op == 6) || (op == 8) || ((op == 9) && ($urandom_range(0, 1) == 1)),
                 addr,
                 (op == 6 && $urandom_range(0, 15) != 0) ? ($urandom & 32'hFFFF_FFFE) : $urandom,
                 a);
        end

        // Reset while a read response is outstanding.
        push_w(32'h0BAD_F00D, a);
        rd_reg(4'h4);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_resp", 32'(bus_resp), 32'd0);
        check_eq("midrst_rdata", bus_rdata, 32'd0);
        check_eq("midrst_ack", 32'(ack), 32'd0);
        model_reset();
        @(negedge clk_gen);
        rst_n = 1'b1;
        rd_reg(4'h4);
        rd_reg(4'h0);
        rd_reg(4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
